// File: rtl/pipemem_ext.sv
// pipemem_ext: MEM stage with byte-enable RAM, extending loads, misalignment trap, wait states and MEM/WB register
module pipemem_ext #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic        mwmem,
    input  logic        mrmem,
    input  logic [1:0]  msize,
    input  logic        munsigned,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mrn,
    output logic        stall,
    output logic        w_valid,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic        w_exc
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [31:0] ram [2**ADDR_BITS];
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic [ADDR_BITS-1:0] idx;
    logic is_h, is_w, acc, misal, mem_op, done, we, ld;
    logic [3:0] be;
    logic [31:0] wdata, rd, ext;
    logic [15:0] hsel;
    logic [7:0] bsel;

    assign idx    = malu[ADDR_BITS+1:2];
    assign is_h   = msize == 2'b01;
    assign is_w   = msize[1];
    assign acc    = mwmem | mrmem;
    assign misal  = (is_h & malu[0]) | (is_w & (malu[1:0] != 2'b00));
    assign mem_op = m_valid & acc & ~misal;
    assign done   = ~stall;
    assign we     = resetn & done & m_valid & mwmem & ~misal;
    assign ld     = m_valid & mrmem & ~mwmem & ~misal;

    assign be    = is_w ? 4'hf : is_h ? (malu[1] ? 4'hc : 4'h3) : 4'b0001 << malu[1:0];
    assign wdata = is_w ? mb : is_h ? {2{mb[15:0]}} : {4{mb[7:0]}};

    assign rd   = ram[idx];
    assign hsel = malu[1] ? rd[31:16] : rd[15:0];
    assign bsel = rd[{malu[1:0], 3'b000} +: 8];
    assign ext  = is_w ? rd
                : is_h ? {{16{~munsigned & hsel[15]}}, hsel}
                :        {{24{~munsigned & bsel[7]}}, bsel};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        if (state == S_IDLE) begin
            if (mem_op && LATENCY != 0) begin
                stall   = 1'b1;
                state_n = S_WAIT;
                cnt_n   = 4'(LATENCY - 1);
            end
        end else if (cnt != 4'd0) begin
            stall = 1'b1;
            cnt_n = cnt - 4'd1;
        end else begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            w_valid <= 1'b0;
            wmo     <= 32'd0;
            walu    <= 32'd0;
            wwreg   <= 1'b0;
            wm2reg  <= 1'b0;
            wrn     <= 5'd0;
            w_exc   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            w_valid <= done & m_valid;
            wmo     <= (done & ld) ? ext : 32'd0;
            walu    <= (done & m_valid) ? malu : 32'd0;
            wwreg   <= done & m_valid & mwreg & ~(acc & misal);
            wm2reg  <= done & m_valid & mm2reg;
            wrn     <= (done & m_valid) ? mrn : 5'd0;
            w_exc   <= done & m_valid & acc & misal;
        end
    end

    // RAM is deliberately outside the reset domain
    always_ff @(posedge clock) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_pipemem_ext.sv
// tb_pipemem_ext: directed checks of a LATENCY=0 and a LATENCY=3 instance sharing one input bus
module tb_pipemem_ext;
    logic clock = 1'b0, resetn = 1'b0;
    logic m_valid = 1'b0, mwmem = 1'b0, mrmem = 1'b0, munsigned = 1'b0, mwreg = 1'b0, mm2reg = 1'b0;
    logic [1:0] msize = 2'b10;
    logic [31:0] malu = 32'd0, mb = 32'd0;
    logic [4:0] mrn = 5'd0;

    logic stall0, w_valid0, wwreg0, wm2reg0, w_exc0;
    logic [31:0] wmo0, walu0;
    logic [4:0] wrn0;
    logic stall3, w_valid3, wwreg3, wm2reg3, w_exc3;
    logic [31:0] wmo3, walu3;
    logic [4:0] wrn3;

    int total = 0, passed = 0;

    always #5 clock = ~clock;

    pipemem_ext #(.ADDR_BITS(6), .LATENCY(0)) u0 (
        .clock(clock), .resetn(resetn), .m_valid(m_valid), .mwmem(mwmem), .mrmem(mrmem),
        .msize(msize), .munsigned(munsigned), .malu(malu), .mb(mb), .mwreg(mwreg),
        .mm2reg(mm2reg), .mrn(mrn), .stall(stall0), .w_valid(w_valid0), .wmo(wmo0),
        .walu(walu0), .wwreg(wwreg0), .wm2reg(wm2reg0), .wrn(wrn0), .w_exc(w_exc0)
    );

    pipemem_ext #(.ADDR_BITS(6), .LATENCY(3)) u3 (
        .clock(clock), .resetn(resetn), .m_valid(m_valid), .mwmem(mwmem), .mrmem(mrmem),
        .msize(msize), .munsigned(munsigned), .malu(malu), .mb(mb), .mwreg(mwreg),
        .mm2reg(mm2reg), .mrn(mrn), .stall(stall3), .w_valid(w_valid3), .wmo(wmo3),
        .walu(walu3), .wwreg(wwreg3), .wm2reg(wm2reg3), .wrn(wrn3), .w_exc(w_exc3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic v, input logic w, input logic r, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] b,
                      input logic wr, input logic m2, input logic [4:0] rn);
        m_valid = v; mwmem = w; mrmem = r; msize = sz; munsigned = u;
        malu = a; mb = b; mwreg = wr; mm2reg = m2; mrn = rn;
        #1;
    endtask

    // Runs the currently driven op on the LATENCY=3 instance, bounding the stall wait
    task automatic run3(input string tag, input int exp_stalls);
        int n = 0;
        while (stall3 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_stalls));
        tick();
    endtask

    initial begin
        op(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_valid", 32'(w_valid0), 0);
        chk("rst_wmo", wmo0, 0);
        chk("rst_walu", walu0, 0);
        chk("rst_exc", 32'(w_exc0), 0);
        chk("rst_stall", 32'(stall0), 0);
        resetn = 1'b1;

        op(1, 1, 0, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, 0);
        chk("st_stall", 32'(stall0), 0);
        tick();
        chk("st_valid", 32'(w_valid0), 1);
        chk("st_wmo", wmo0, 0);
        op(1, 0, 1, 2'b10, 0, 32'h10, 0, 1, 1, 5);
        chk("ld_stall", 32'(stall0), 0);
        tick();
        chk("ld_wmo", wmo0, 32'h11223344);
        chk("ld_wwreg", 32'(wwreg0), 1);
        chk("ld_wm2reg", 32'(wm2reg0), 1);
        chk("ld_wrn", 32'(wrn0), 5);
        chk("ld_walu", walu0, 32'h10);

        op(1, 1, 0, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 0, 0); tick();
        op(1, 0, 1, 2'b00, 0, 32'h22, 0, 1, 1, 1); tick();
        chk("lb_s", wmo0, 32'hFFFFFFFF);
        op(1, 0, 1, 2'b00, 1, 32'h21, 0, 1, 1, 1); tick();
        chk("lbu", wmo0, 32'h0000007F);
        op(1, 0, 1, 2'b01, 0, 32'h22, 0, 1, 1, 1); tick();
        chk("lh_s", wmo0, 32'hFFFF80FF);
        op(1, 0, 1, 2'b01, 1, 32'h20, 0, 1, 1, 1); tick();
        chk("lhu", wmo0, 32'h00007F01);

        op(1, 1, 0, 2'b10, 0, 32'h30, 32'hAAAAAAAA, 0, 0, 0); tick();
        op(1, 1, 0, 2'b00, 0, 32'h31, 32'hDEADBE55, 0, 0, 0); tick();
        op(1, 1, 0, 2'b01, 0, 32'h32, 32'hFFFF1234, 0, 0, 0); tick();
        op(1, 0, 1, 2'b10, 0, 32'h30, 0, 1, 1, 2); tick();
        chk("partial", wmo0, 32'h123455AA);

        op(1, 0, 1, 2'b10, 0, 32'h06, 0, 1, 1, 3);
        chk("mis_stall", 32'(stall0), 0);
        tick();
        chk("mis_exc", 32'(w_exc0), 1);
        chk("mis_wwreg", 32'(wwreg0), 0);
        chk("mis_wmo", wmo0, 0);
        op(1, 1, 0, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0); tick();
        chk("st_noexc", 32'(w_exc0), 0);
        op(1, 1, 0, 2'b01, 0, 32'h41, 32'h00001111, 0, 0, 0); tick();
        chk("mis_st_exc", 32'(w_exc0), 1);
        op(1, 0, 1, 2'b10, 0, 32'h40, 0, 1, 1, 4); tick();
        chk("mis_st_ram", wmo0, 32'hCAFEF00D);
        chk("mis_st_exc_clr", 32'(w_exc0), 0);

        op(0, 0, 1, 2'b10, 0, 32'h40, 0, 1, 1, 4); tick();
        chk("bub_valid", 32'(w_valid0), 0);
        chk("bub_wwreg", 32'(wwreg0), 0);
        chk("bub_wmo", wmo0, 0);

        resetn = 1'b0;
        op(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        resetn = 1'b1;
        chk("l3_rst_stall", 32'(stall3), 0);

        op(1, 1, 0, 2'b10, 0, 32'h50, 32'h5A5A5A5A, 0, 0, 0);
        run3("l3_st_stalls", 3);
        op(1, 0, 1, 2'b10, 0, 32'h50, 0, 1, 1, 7);
        chk("w_c0_stall", 32'(stall3), 1);
        tick();
        chk("w_c1_stall", 32'(stall3), 1);
        chk("w_c1_bubble", 32'(w_valid3), 0);
        tick();
        chk("w_c2_stall", 32'(stall3), 1);
        chk("w_c2_wwreg", 32'(wwreg3), 0);
        tick();
        chk("w_c3_stall", 32'(stall3), 0);
        chk("w_c3_bubble", 32'(w_valid3), 0);
        tick();
        chk("w_done_valid", 32'(w_valid3), 1);
        chk("w_done_wmo", wmo3, 32'h5A5A5A5A);
        chk("w_done_wrn", 32'(wrn3), 7);
        op(1, 0, 0, 2'b10, 0, 32'h12345678, 0, 1, 0, 9);
        chk("alu_stall", 32'(stall3), 0);
        tick();
        chk("alu_walu", walu3, 32'h12345678);
        chk("alu_valid", 32'(w_valid3), 1);
        chk("alu_wmo", wmo3, 0);

        op(1, 1, 0, 2'b10, 0, 32'h50, 32'hDEADBEEF, 0, 0, 0);
        chk("rw_c0_stall", 32'(stall3), 1);
        tick();
        chk("rw_c1_stall", 32'(stall3), 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        op(0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        chk("rw_stall", 32'(stall3), 0);
        chk("rw_valid", 32'(w_valid3), 0);
        chk("rw_walu", walu3, 0);
        chk("rw_wmo", wmo3, 0);
        op(1, 0, 1, 2'b10, 0, 32'h50, 0, 1, 1, 8);
        run3("rw_ld_stalls", 3);
        chk("rw_unchanged", wmo3, 32'h5A5A5A5A);

        op(1, 1, 0, 2'b10, 0, 32'h104, 32'h0BADC0DE, 0, 0, 0);
        run3("wrap_st_stalls", 3);
        op(1, 0, 1, 2'b10, 0, 32'h004, 0, 1, 1, 10);
        run3("wrap_ld_stalls", 3);
        chk("wrap_wmo", wmo3, 32'h0BADC0DE);
        chk("wrap_walu", walu3, 32'h004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
